// File: rtl/timer_pkg.sv
// Shared types for the countdown timer and its prescale divider.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/tick_divider.sv
// Prescale divider: emits one tick every (prescale+1) enabled cycles.
// The compare uses >= so that lowering prescale below the current
// prescaler value mid-run ticks at the next compare instead of wrapping
// through the full register range.
module tick_divider #(
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);

    logic [PRESCALE_WIDTH-1:0] presc;

    assign tick = enable && (presc >= prescale);

    // Prescaler advances only while enabled and wraps to 0 on each tick.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            presc <= '0;
        end else if (enable) begin
            if (tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter / interval timer with prescaler, sticky expiry
// flag and optional auto-reload.
//
//   state | meaning
//   ------+------------------------------------------
//   IDLE  | value loaded, waiting for start
//   RUN   | counting down on prescaled ticks
//   DONE  | expired, holding count until start/load
module countdown_timer
    import timer_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [WIDTH-1:0]          load_value,
    input  logic                      start,
    input  logic                      enable,
    input  logic                      auto_reload,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [WIDTH-1:0]          count,
    output logic                      busy,
    output logic                      done,
    output logic                      expired
);

    timer_state_t     state;
    logic [WIDTH-1:0] reload;
    logic             presc_clear;
    logic             presc_en;
    logic             tick;

    // A load or an accepted start restarts the prescale phase.
    assign presc_clear = load || (start && (state != RUN));
    assign presc_en    = (state == RUN) && enable;

    tick_divider #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_tick_divider (
        .clk      (clk),
        .reset    (reset),
        .clear    (presc_clear),
        .enable   (presc_en),
        .prescale (prescale),
        .tick     (tick)
    );

    // Control FSM with the count and reload registers; all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            reload  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                reload  <= load_value;
                count   <= load_value;
                expired <= 1'b0;
                busy    <= 1'b0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (count != '0) begin
                                state   <= RUN;
                                busy    <= 1'b1;
                                expired <= 1'b0;
                            end else begin
                                state   <= DONE;
                                done    <= 1'b1;
                                expired <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        // Re-arm from the reload value; an empty reload
                        // expires again immediately.
                        if (start) begin
                            count <= reload;
                            if (reload != '0) begin
                                state   <= RUN;
                                busy    <= 1'b1;
                                expired <= 1'b0;
                            end else begin
                                done    <= 1'b1;
                                expired <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            if (count > WIDTH'(1)) begin
                                count <= count - WIDTH'(1);
                            end else begin
                                done    <= 1'b1;
                                expired <= 1'b1;
                                if (auto_reload && (reload != '0)) begin
                                    count <= reload;
                                end else begin
                                    count <= '0;
                                    busy  <= 1'b0;
                                    state <= DONE;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with hand-computed expectations.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [7:0] load_value;
    logic       start;
    logic       enable;
    logic       auto_reload;
    logic [3:0] prescale;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       expired;

    int nvec = 0;
    int nmis = 0;

    countdown_timer #(
        .WIDTH          (8),
        .PRESCALE_WIDTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .enable      (enable),
        .auto_reload (auto_reload),
        .prescale    (prescale),
        .count       (count),
        .busy        (busy),
        .done        (done),
        .expired     (expired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        load       = 1'b1;
        load_value = v;
        step();
        load       = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        load        = 1'b0;
        load_value  = '0;
        start       = 1'b0;
        enable      = 1'b1;
        auto_reload = 1'b0;
        prescale    = 4'd0;
        step();
        step();
        reset = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_expired", expired, 0);

        // Load 5, prescale 0: 5,4,3,2,1,0 on consecutive cycles.
        do_load(8'd5);
        chk("t1_load_count", count, 5);
        chk("t1_load_busy", busy, 0);
        do_start();
        chk("t1_start_count", count, 5);
        chk("t1_start_busy", busy, 1);
        for (int i = 4; i >= 1; i--) begin
            step();
            chk("t1_count", count, i);
            chk("t1_done_low", done, 0);
        end
        step();
        chk("t1_end_count", count, 0);
        chk("t1_done", done, 1);
        chk("t1_busy_fall", busy, 0);
        chk("t1_expired", expired, 1);
        step();
        chk("t1_done_once", done, 0);
        chk("t1_expired_sticky", expired, 1);
        // Start in DONE re-arms from the reload value.
        do_start();
        chk("t1_rearm_count", count, 5);
        chk("t1_rearm_busy", busy, 1);
        chk("t1_rearm_expired", expired, 0);

        // Load 3, prescale 2: decrement every 3 cycles, done 9 cycles after start.
        prescale = 4'd2;
        do_load(8'd3);
        chk("t2_load_busy", busy, 0);
        do_start();
        for (int c = 1; c <= 9; c++) begin
            step();
            chk("t2_count", count, 3 - c / 3);
            chk("t2_done", done, (c == 9) ? 1 : 0);
        end
        chk("t2_busy", busy, 0);

        // Load 4, pause 6 cycles at count 2: done 6 cycles late (edge k+10).
        prescale = 4'd0;
        do_load(8'd4);
        do_start();
        step();
        chk("t3_count3", count, 3);
        step();
        chk("t3_count2", count, 2);
        enable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("t3_hold_count", count, 2);
            chk("t3_hold_busy", busy, 1);
            chk("t3_hold_done", done, 0);
        end
        enable = 1'b1;
        step();
        chk("t3_count1", count, 1);
        chk("t3_done_early", done, 0);
        step();
        chk("t3_count0", count, 0);
        chk("t3_done", done, 1);

        // Load 2 with auto-reload: 2,1,2,1..., done every 2 cycles, never DONE.
        auto_reload = 1'b1;
        do_load(8'd2);
        do_start();
        chk("t4_start_count", count, 2);
        for (int c = 1; c <= 8; c++) begin
            step();
            chk("t4_count", count, (c % 2 == 1) ? 1 : 2);
            chk("t4_done", done, (c % 2 == 0) ? 1 : 0);
            chk("t4_busy", busy, 1);
        end
        auto_reload = 1'b0;
        step();
        chk("t4_tail_count", count, 1);
        step();
        chk("t4_final_count", count, 0);
        chk("t4_final_done", done, 1);
        chk("t4_final_busy", busy, 0);

        // Load 0 then start: straight to DONE; then load 7 (with start, load wins).
        do_load(8'd0);
        do_start();
        chk("t5_done", done, 1);
        chk("t5_expired", expired, 1);
        chk("t5_busy", busy, 0);
        chk("t5_count", count, 0);
        start = 1'b1;
        do_load(8'd7);
        start = 1'b0;
        chk("t5_reload_expired", expired, 0);
        chk("t5_reload_count", count, 7);
        chk("t5_reload_busy", busy, 0);
        chk("t5_reload_done", done, 0);
        step();
        chk("t5_idle_busy", busy, 0);

        // Load 9, start, reset at count 4; start afterwards goes straight to DONE.
        do_load(8'd9);
        do_start();
        for (int c = 0; c < 5; c++) step();
        chk("t6_count4", count, 4);
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_expired", expired, 0);
        chk("t6_rst_done", done, 0);
        do_start();
        chk("t6_start_done", done, 1);
        chk("t6_start_expired", expired, 1);
        chk("t6_start_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter and interval timer: the decrementing counterpart of the team's up-counter. A value is loaded, a start command arms it, and the count decrements on prescaled ticks while `enable` is high. When the count reaches zero the block emits a one-cycle `done` pulse and sets a sticky `expired` flag. With auto-reload on, it restarts from the loaded value. It sits beside the up-counter in arithmetic/control datapaths as the timeout and iteration-limit source.

## Interface
- `WIDTH`, 8: width of the count and load value.
- `PRESCALE_WIDTH`, 4: width of the prescale setting.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  one-cycle command to capture `load_value`.
- `load_value`  in  WIDTH  start and reload value.
- `start`  in  1  one-cycle command to arm the countdown.
- `enable`  in  1  level; low freezes the prescaler and the count (pause).
- `auto_reload`  in  1  level; sampled at each terminal tick.
- `prescale`  in  PRESCALE_WIDTH  the count decrements once every `prescale`+1 enabled cycles.
- `count`  out  WIDTH  current remaining count.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse on expiry.
- `expired`  out  1  sticky expiry flag.

## Operation
- States:
  - IDLE: loaded, not running.
  - RUN: counting down.
  - DONE: expired, holding.
- Reset: state IDLE. `count`, reload register, prescaler, `busy`, `done` and `expired` all 0.
- `load`, in any state:
  - reload register and `count` take `load_value`.
  - prescaler clears, `expired` clears, state goes to IDLE.
  - `load` has priority over `start` and over a tick in the same cycle.
- `start` in IDLE:
  - If `count`≠0: go to RUN, prescaler clears, `expired` clears.
  - If `count`=0: go to DONE, `done` pulses, `expired` sets.
- `start` in DONE: `count` takes the reload register value, then the same rules as `start` in IDLE apply.
- `start` in RUN is ignored.
- Prescaler:
  - Counts only in RUN with `enable`=1.
  - A tick fires when the prescaler equals `prescale`; the prescaler then wraps to 0.
  - With `prescale`=0, every enabled cycle is a tick.
  - A change to `prescale` mid-run takes effect at the next compare.
- Tick in RUN with `count`>1: `count` decrements by 1.
- Tick in RUN with `count`=1 (terminal):
  - `done` pulses and `expired` sets.
  - If `auto_reload`=1 and the reload register ≠0: `count` takes the reload register value and the state stays RUN.
  - Otherwise `count` goes to 0 and the state goes to DONE.
- `enable`=0 in RUN holds everything; `busy` stays 1.
- `done` is a registered pulse, never high for two consecutive cycles unless two terminal ticks are consecutive (auto-reload with reload=1 and `prescale`=0).
- Arithmetic is unsigned and `count` never wraps below 0.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- Latency: load N≥1, `start` sampled at edge k, `enable` held high. `done` is high during the cycle following edge k+N·(`prescale`+1). `busy` falls at that same edge unless auto-reload applies.
- `busy` rises at the edge that samples `start`.
- `load` and `start` are single-cycle commands. Holding `start` high in RUN has no effect. Holding it high in DONE re-arms every cycle.
- `reset` mid-run overrides all inputs in that cycle. The next cycle shows IDLE with every output 0.

## Structure
- Shared package `timer_pkg`: enum `timer_state_t` {IDLE, RUN, DONE}.
- One sub-module, `tick_divider`:
  - Ports: clk, reset, clear, enable, prescale; output: tick.
  - Holds the prescaler register and compare.
- The top level holds the FSM, the count register and the reload register.

## Test plan
- Reset, load 5, start, `prescale`=0, `enable`=1 → `count` reads 5,4,3,2,1,0 on consecutive cycles; `done` is high one cycle; `busy` falls; `expired`=1.
- Load 3, `prescale`=2, start → a decrement every 3 cycles; `done` is high 9 cycles after the start edge.
- Load 4, start, drop `enable` for 6 cycles at count 2 → count holds 2, `busy`=1; `done` arrives 6 cycles later than in the unpaused case.
- Load 2, `auto_reload`=1, `prescale`=0 → `count` reads 2,1,2,1…; `done` pulses every 2 cycles; state never reaches DONE.
- Load 0 then start → DONE next cycle with `done`=1, `expired`=1. Then load 7 → `expired`=0, `count`=7, IDLE.
- Load 9, start, assert `reset` at count 4 → next cycle `count`=0, `busy`=0, `expired`=0. A following start with no load goes straight to DONE.
